elastic_pipeline: RTL
=====================

// Module: elastic_pipeline
// PURPOSE
//  Multi-stage data pipeline with valid/ready flow control; stalls propagate
//  upstream one stage per cycle so no combinational ready path spans stages.
//  Used wherever a fixed-latency register pipeline must absorb downstream
//  backpressure without dropping or duplicating data. Full throughput, 1 word/cycle.
// PARAMETERS
//  p_width   32  data width in bits
//  p_stages  4   number of elastic stages (>=1); unstalled latency = p_stages cycles
// PORTS
//  i_clk     in   1        clock; all state on posedge
//  i_rst_n   in   1        async active-low reset
//  i_valid   in   1        upstream word valid
//  o_ready   out  1        pipeline accepts word this cycle (registered, stage 0)
//  i_data    in   p_width  upstream word
//  o_valid   out  1        output word valid (last stage)
//  i_ready   in   1        downstream accepts word this cycle
//  o_data    out  p_width  output word
//  o_count   out  $clog2(2*p_stages+1)  occupancy; only with ELASTIC_PIPELINE_STATS_EN
// BEHAVIOUR
//  - One clock i_clk; reset asynchronous, active-low (i_rst_n).
//  - Reset: every stage EMPTY; o_valid=0, o_ready=1, o_data=0, o_count=0.
//  - Transfer ("fire") on a port when valid && ready in the same cycle.
//  - Each stage = main reg + skid reg, FSM {EMPTY, BUSY, FULL}:
//      EMPTY: out_valid=0, in_ready=1; in fire -> BUSY (main<=in).
//      BUSY : out_valid=1, in_ready=1; in&out fire -> BUSY (main<=in);
//             in fire only -> FULL (skid<=in); out fire only -> EMPTY.
//      FULL : out_valid=1, in_ready=0; out fire -> BUSY (main<=skid).
//  - in_ready is a decode of stage state flops only (never of downstream ready).
//  - Stage k output feeds stage k+1 input; o_valid/o_data from stage p_stages-1.
//  - Latency: word accepted at cycle t appears on o_data at t+p_stages if unstalled.
//  - Capacity 2*p_stages words; o_ready falls only when stage 0 is FULL.
//  - Strict FIFO order; no loss, no duplication; o_data stable while
//    o_valid && !i_ready.
//  - i_valid deasserted with o_ready=1: no state change in stage 0.
//  - Reset asserted mid-operation: all words discarded immediately, outputs
//    to reset values asynchronously.
//  - Data regs updated only on load; not reset-dependent beyond reset to 0.
// CONFIGURATION
//  - ELASTIC_PIPELINE_STATS_EN defined: o_count present; +1 on input fire,
//    -1 on output fire, unchanged on both/neither; saturates never (bounded
//    by capacity).
//  - Not defined: o_count port and counter absent; datapath identical.
// STRUCTURE
//  - Package elastic_pipeline_pkg: typedef enum logic [1:0]
//    {ST_EMPTY, ST_BUSY, ST_FULL} stage_state_e.
//  - Sub-module elastic_stage (one stage: FSM + main/skid regs, p_width param),
//    instantiated p_stages times in a generate loop g_stage over a
//    valid/ready/data routing array of p_stages+1 entries.
// TESTING (p_width=32, p_stages=4)
//  - Streaming: i_ready=1, i_valid=1, data 1..100 -> o_data 1..100 in order,
//    first at 4 cycles after first accept, o_ready never 0.
//  - Full stall: i_ready=0, push 0xA0..0xA9 -> exactly 8 accepted, o_ready=0
//    after 8th, o_count=8; release i_ready -> 0xA0..0xA7 out in order.
//  - Backpressure toggle: i_ready random 50%, i_valid random -> scoreboard
//    match, no drops/dups, o_data stable while o_valid && !i_ready.
//  - Bubbles: i_valid on alternate cycles, i_ready=1 -> o_valid alternates,
//    same latency 4, o_count stays <=4.
//  - Reset mid-stream: 5 words held, i_rst_n low 1 cycle -> o_valid=0,
//    o_ready=1, o_count=0 at once; next word 0x55 exits alone after 4 cycles.
//  - Simultaneous in/out fire with pipe FULL drained by one: o_count unchanged.

Source files
------------

// File: rtl/elastic_pipeline_pkg.sv
// Shared types for the elastic pipeline: the per-stage occupancy state.
package elastic_pipeline_pkg;

   // EMPTY: nothing held; BUSY: main reg holds a word; FULL: main and skid both hold words.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } stage_state_e;

endpackage

// File: rtl/elastic_stage.sv
// One elastic stage: a main register plus a skid register under a three-state FSM.
// Upstream ready is decoded from the state flops only. The downstream ready
// therefore never reaches the upstream ready through combinational logic.
module elastic_stage
   import elastic_pipeline_pkg::*;
#(
   parameter int p_width = 32
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [p_width-1:0] i_data,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [p_width-1:0] o_data
);

   stage_state_e       state_q, state_d;
   logic [p_width-1:0] main_q, main_d;
   logic [p_width-1:0] skid_q, skid_d;
   logic               in_fire;
   logic               out_fire;

   assign o_valid  = (state_q != ST_EMPTY);
   assign o_ready  = (state_q != ST_FULL);
   assign o_data   = main_q;
   assign in_fire  = i_valid && o_ready;
   assign out_fire = o_valid && i_ready;

   // Next-state and register-load decode for the stage FSM.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               state_d = ST_BUSY;
               main_d  = i_data;
            end
         end
         ST_BUSY: begin
            if (in_fire && out_fire) begin
               main_d = i_data;
            end else if (in_fire) begin
               state_d = ST_FULL;
               skid_d  = i_data;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_fire) begin
               state_d = ST_BUSY;
               main_d  = skid_q;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   // State and data registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         // NOTE: the data registers are cleared too, so o_data reads 0 out of reset rather than X.
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: rtl/elastic_pipeline.sv
// Elastic pipeline of p_stages elastic_stage instances chained by valid/ready.
// Total capacity is 2*p_stages words. Unstalled latency is p_stages cycles.
// Optional feature: define ELASTIC_PIPELINE_STATS_EN to add the o_count
// occupancy output and its counter.
module elastic_pipeline
   import elastic_pipeline_pkg::*;
#(
   parameter int p_width  = 32,
   parameter int p_stages = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [p_width-1:0] i_data,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [p_width-1:0] o_data
`ifdef ELASTIC_PIPELINE_STATS_EN
   ,
   output logic [$clog2(2*p_stages+1)-1:0] o_count
`endif
);

   // Routing array: entry k is the input side of stage k, and entry k+1 is its output side.
   logic               valid_r [p_stages+1];
   logic               ready_r [p_stages+1];
   logic [p_width-1:0] data_r  [p_stages+1];

   assign valid_r[0]        = i_valid;
   assign data_r[0]         = i_data;
   assign o_ready           = ready_r[0];
   assign o_valid           = valid_r[p_stages];
   assign o_data            = data_r[p_stages];
   assign ready_r[p_stages] = i_ready;

   for (genvar k = 0; k < p_stages; k++) begin : g_stage
      elastic_stage #(
         .p_width (p_width)
      ) u_stage (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_valid (valid_r[k]),
         .o_ready (ready_r[k]),
         .i_data  (data_r[k]),
         .o_valid (valid_r[k+1]),
         .i_ready (ready_r[k+1]),
         .o_data  (data_r[k+1])
      );
   end

`ifdef ELASTIC_PIPELINE_STATS_EN
   localparam int c_cnt_w = $clog2(2*p_stages+1);

   logic               in_fire;
   logic               out_fire;
   logic [c_cnt_w-1:0] count_q, count_d;

   assign in_fire  = i_valid && o_ready;
   assign out_fire = o_valid && i_ready;
   assign o_count  = count_q;

   // Occupancy is +1 on an input fire and -1 on an output fire. It is unchanged on both or neither.
   always_comb begin
      count_d = count_q;
      case ({in_fire, out_fire})
         2'b10:   count_d = count_q + c_cnt_w'(1);
         2'b01:   count_d = count_q - c_cnt_w'(1);
         default: count_d = count_q;
      endcase
   end

   // Occupancy register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end
`else
   // Occupancy tracking is not built. The datapath above is unchanged.
`endif

endmodule
